pipe_stage_skid: RTL and testbench

- Generic, parametrised pipeline stage register for the core pipeline (F/D/E/M boundaries).
- Uses a valid/ready handshake in both directions, with an optional skid buffer so stalls do not create a combinational ready path.
- Provides a synchronous flush and a programmable squash counter that drops the next N accepted upstream beats (branch/load-use bubbles).
- All payload fields of a stage are carried as one packed WIDTH-bit bus.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_kill_ctr.sv | 39 +++
 rtl/pipe_stage_skid.sv | 128 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: occupancy encodings, default squash width and
// per-stage payload widths built from their field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int unsigned PIPE_KILL_W = 2;

  localparam int unsigned PIPE_PC_W     = 32;
  localparam int unsigned PIPE_INSTR_W  = 32;
  localparam int unsigned PIPE_XLEN     = 32;
  localparam int unsigned PIPE_RD_W     = 5;
  localparam int unsigned PIPE_CTRL_W   = 8;

  localparam int unsigned PIPE_F_W = PIPE_PC_W + PIPE_INSTR_W;
  localparam int unsigned PIPE_D_W = PIPE_PC_W + 3 * PIPE_XLEN + PIPE_RD_W + PIPE_CTRL_W;
  localparam int unsigned PIPE_E_W = PIPE_PC_W + 2 * PIPE_XLEN + PIPE_RD_W + PIPE_CTRL_W;
  localparam int unsigned PIPE_M_W = PIPE_XLEN + PIPE_RD_W + 1;

endpackage

// File: rtl/pipe_kill_ctr.sv
// Squash counter: synchronous clear, load, and decrement that saturates at 0.
module pipe_kill_ctr
  import pipe_pkg::*;
#(
  parameter int unsigned KILL_W = PIPE_KILL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [KILL_W-1:0] load_val,
  input  logic              dec,
  output logic              nonzero
);

  logic [KILL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - KILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a programmable squash of upcoming accepted beats.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned KILL_W = PIPE_KILL_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              _clk,
  input  logic              _rst,
  input  logic              _valid,
  input  logic [WIDTH-1:0]  _data,
  output logic              ready_,
  output logic              valid_,
  output logic [WIDTH-1:0]  data_,
  input  logic              _ready,
  input  logic              _flush,
  input  logic              _kill_load,
  input  logic [KILL_W-1:0] _kill_n,
  output logic              kill_pending_,
  output logic [1:0]        occupancy_
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic ut;
  logic dt;
  logic store;
  logic squash;

  assign ut     = _valid && ready_;
  assign dt     = valid_ && _ready;
  // Squash is judged against the count before any same-cycle load.
  assign store  = ut && !kill_pending_ && !_flush;
  assign squash = ut && kill_pending_ && !_flush;

  pipe_kill_ctr #(
    .KILL_W (KILL_W)
  ) u_kill_ctr (
    .clk      (_clk),
    .rst      (_rst),
    .clr      (_flush),
    .load     (_kill_load),
    .load_val (_kill_n),
    .dec      (squash),
    .nonzero  (kill_pending_)
  );

  always_ff @(posedge _clk) begin
    if (_rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (_flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (store) begin
            occ_d  = OCC_ONE;
            main_d = _data;
          end
        end
        OCC_ONE: begin
          if (dt && store) begin
            main_d = _data;
          end else if (dt) begin
            occ_d = OCC_EMPTY;
          end else if (store) begin
            occ_d  = OCC_FULL;
            skid_d = _data;
          end
        end
        OCC_FULL: begin
          if (dt) begin
            occ_d  = OCC_ONE;
            main_d = skid_q;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_     = (occ_q != OCC_EMPTY);
    occupancy_ = occ_q;
    data_      = main_q;
  end

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q, ready_d;

      // Registered ready breaks the combinational path from downstream ready.
      always_comb begin
        ready_d = (occ_d != OCC_FULL);
      end

      always_ff @(posedge _clk) begin
        if (_rst) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= ready_d;
        end
      end

      assign ready_ = ready_q;
    end else begin : g_noskid
      assign ready_ = !valid_ || _ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: scoreboarded SKID=1 stage plus
// directed checks on a SKID=0 stage.
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       rst;
  logic       vin;
  logic [7:0] din;
  logic       rdy;
  logic       flush;
  logic       kload;
  logic [1:0] kn;
  logic       ready_o, valid_o, kp_o;
  logic [7:0] data_o;
  logic [1:0] occ_o;

  logic       v2, r2;
  logic [7:0] d2;
  logic       ready2, valid2, kp2;
  logic [7:0] data2;
  logic [1:0] occ2;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q[$];
  int         k_model = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(8), .KILL_W(2), .SKID(1)) dut (
    ._clk          (clk),
    ._rst          (rst),
    ._valid        (vin),
    ._data         (din),
    .ready_        (ready_o),
    .valid_        (valid_o),
    .data_         (data_o),
    ._ready        (rdy),
    ._flush        (flush),
    ._kill_load    (kload),
    ._kill_n       (kn),
    .kill_pending_ (kp_o),
    .occupancy_    (occ_o)
  );

  pipe_stage_skid #(.WIDTH(8), .KILL_W(2), .SKID(0)) dut0 (
    ._clk          (clk),
    ._rst          (rst),
    ._valid        (v2),
    ._data         (d2),
    .ready_        (ready2),
    .valid_        (valid2),
    .data_         (data2),
    ._ready        (r2),
    ._flush        (1'b0),
    ._kill_load    (1'b0),
    ._kill_n       (2'd0),
    .kill_pending_ (kp2),
    .occupancy_    (occ2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 0);
    chk({tag, "_data"},  32'(data_o), 0);
    chk({tag, "_occ"},   32'(occ_o), 0);
    chk({tag, "_kp"},    32'(kp_o), 0);
    chk({tag, "_ready"}, 32'(ready_o), 1);
  endtask

  // Reference model for the SKID=1 stage, evaluated just before each edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      k_model = 0;
    end else begin
      if (valid_o && rdy) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'(q.size()), 1);
        end else begin
          chk("sb_data", 32'(data_o), 32'(q.pop_front()));
        end
      end
      if (flush) begin
        q.delete();
        k_model = 0;
      end else begin
        if (vin && ready_o) begin
          if (k_model != 0) k_model--;
          else q.push_back(din);
        end
        if (kload) k_model = int'(kn);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vin = 1'b0; din = '0; rdy = 1'b0; flush = 1'b0;
    kload = 1'b0; kn = '0; v2 = 1'b0; d2 = '0; r2 = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_reset("reset");
    chk("reset0_ready", 32'(ready2), 1);

    // Streaming
    rdy = 1'b1; vin = 1'b1;
    din = 8'h11; step();
    chk("str_d11", 32'(data_o), 32'h11);
    din = 8'h22; step();
    chk("str_d22", 32'(data_o), 32'h22);
    chk("str_rdy", 32'(ready_o), 1);
    din = 8'h33; step();
    chk("str_d33", 32'(data_o), 32'h33);
    chk("str_occ", 32'(occ_o), 1);
    vin = 1'b0; step();
    chk("str_empty", 32'(occ_o), 0);

    // Backpressure
    rdy = 1'b0; vin = 1'b1;
    din = 8'hA1; step();
    din = 8'hA2; step();
    vin = 1'b0;
    chk("bp_occ", 32'(occ_o), 2);
    chk("bp_ready", 32'(ready_o), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", 32'(data_o), 32'hA1);
      chk("bp_hold_v", 32'(valid_o), 1);
    end
    rdy = 1'b1; step();
    chk("bp_next", 32'(data_o), 32'hA2);
    chk("bp_ready1", 32'(ready_o), 1);
    step();
    chk("bp_drain", 32'(occ_o), 0);

    // Squash two beats
    kload = 1'b1; kn = 2'd2; step();
    kload = 1'b0;
    chk("sq_kp", 32'(kp_o), 1);
    vin = 1'b1; din = 8'hB1; step();
    chk("sq_b1_gone", 32'(valid_o), 0);
    din = 8'hB2; step();
    chk("sq_kp_fall", 32'(kp_o), 0);
    chk("sq_b2_gone", 32'(valid_o), 0);
    din = 8'hB3; step();
    vin = 1'b0;
    chk("sq_b3", 32'(data_o), 32'hB3);
    step();

    // Flush while full with a pending squash
    rdy = 1'b0; vin = 1'b1;
    din = 8'hC1; step();
    din = 8'hC2; step();
    vin = 1'b0; kload = 1'b1; kn = 2'd1; step();
    kload = 1'b0;
    chk("fl_occ2", 32'(occ_o), 2);
    chk("fl_kp1", 32'(kp_o), 1);
    flush = 1'b1; vin = 1'b1; din = 8'hC3; step();
    flush = 1'b0; vin = 1'b0;
    chk("fl_valid", 32'(valid_o), 0);
    chk("fl_occ", 32'(occ_o), 0);
    chk("fl_kp", 32'(kp_o), 0);
    chk("fl_ready", 32'(ready_o), 1);

    // Flush discards a same-cycle beat and ignores a same-cycle kill load
    vin = 1'b1; din = 8'hC4; step();
    flush = 1'b1; din = 8'hC5; kload = 1'b1; kn = 2'd3; step();
    flush = 1'b0; vin = 1'b0; kload = 1'b0;
    chk("fl2_valid", 32'(valid_o), 0);
    chk("fl2_kp", 32'(kp_o), 0);
    rdy = 1'b1; step(); step();

    // Beat accepted alongside kill load is judged against old count
    vin = 1'b1; din = 8'hD1; kload = 1'b1; kn = 2'd1; step();
    kload = 1'b0;
    chk("sim_d1", 32'(data_o), 32'hD1);
    chk("sim_kp", 32'(kp_o), 1);
    din = 8'hD2; step();
    vin = 1'b0;
    chk("sim_d2_gone", 32'(valid_o), 0);
    chk("sim_kp0", 32'(kp_o), 0);

    // Loading zero cancels a pending squash
    kload = 1'b1; kn = 2'd2; step();
    kn = 2'd0; step();
    kload = 1'b0;
    chk("cancel_kp", 32'(kp_o), 0);

    // Reset while full
    rdy = 1'b0; vin = 1'b1;
    din = 8'hE1; step();
    din = 8'hE2; step();
    vin = 1'b0;
    chk("rst_full", 32'(occ_o), 2);
    rst = 1'b1; step();
    rst = 1'b0;
    chk_reset("rst_mid");
    rdy = 1'b1; step();

    // SKID=0: combinational ready and same-cycle replace
    r2 = 1'b0; v2 = 1'b1; d2 = 8'h51; step();
    v2 = 1'b0; #1;
    chk("s0_ready0", 32'(ready2), 0);
    chk("s0_d51", 32'(data2), 32'h51);
    r2 = 1'b1; #1;
    chk("s0_ready1", 32'(ready2), 1);
    v2 = 1'b1; d2 = 8'h52; step();
    chk("s0_valid", 32'(valid2), 1);
    chk("s0_replace", 32'(data2), 32'h52);
    chk("s0_occ", 32'(occ2), 1);
    v2 = 1'b0; r2 = 1'b0; step();
    chk("s0_hold", 32'(data2), 32'h52);

    step();
    chk("sb_drain", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
